rtc_bus_arbiter: RTL

Shares the single RTC bus-transaction engine (the address/data-multiplexed write/read sequencer that drives a_d, cs, rd, wr) among three clients: the RTC initialization sequencer, the user-write sequencer and the periodic-read sequencer. It grants the engine to one client at a time, holds the grant for exactly one fixed-length transaction, and inserts a bus-idle gap between transactions. It also drives the engine's do_it/w_r inputs and the datapath source-select.

---
 rtl/rtc_bus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rtc_bus_arbiter.sv
// Grants the shared RTC bus-transaction engine to one of three clients (init, user write,
// periodic read) for one fixed-length transaction, followed by a bus-idle gap.
module rtc_bus_arbiter #(
   parameter int TXN_CYCLES = 43,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_init,
   input  logic       req_wr,
   input  logic       req_rd,
   input  logic       w_r_init,
   input  logic       w_r_wr,
   input  logic       w_r_rd,
   output logic       do_it,
   output logic       w_r,
   output logic [1:0] sel,
   output logic       gnt_init,
   output logic       gnt_wr,
   output logic       gnt_rd,
   output logic       done_init,
   output logic       done_wr,
   output logic       done_rd,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_INIT = 2'b01;
   localparam logic [1:0] SRC_WR   = 2'b10;
   localparam logic [1:0] SRC_RD   = 2'b11;

   localparam logic [5:0] TXN_LAST = 6'(TXN_CYCLES - 1);
   localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

   state_t     state;
   logic [5:0] count;
   logic [1:0] owner;
   logic       last_rw;

   logic [1:0] pick;
   logic       pick_w_r;

   // Init wins outright; wr/rd contention alternates on whichever was not served last.
   always_comb begin
      pick = SRC_NONE;
      if (req_init)
         pick = SRC_INIT;
      else if (req_wr && req_rd)
         pick = last_rw ? SRC_WR : SRC_RD;
      else if (req_wr)
         pick = SRC_WR;
      else if (req_rd)
         pick = SRC_RD;
   end

   always_comb begin
      pick_w_r = 1'b0;
      case (pick)
         SRC_INIT: pick_w_r = w_r_init;
         SRC_WR:   pick_w_r = w_r_wr;
         SRC_RD:   pick_w_r = w_r_rd;
         default:  pick_w_r = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         owner     <= SRC_NONE;
         last_rw   <= 1'b0;
         do_it     <= 1'b0;
         w_r       <= 1'b0;
         sel       <= SRC_NONE;
         gnt_init  <= 1'b0;
         gnt_wr    <= 1'b0;
         gnt_rd    <= 1'b0;
         done_init <= 1'b0;
         done_wr   <= 1'b0;
         done_rd   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done_init <= 1'b0;
         done_wr   <= 1'b0;
         done_rd   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick != SRC_NONE) begin
                  state    <= GRANT;
                  owner    <= pick;
                  sel      <= pick;
                  w_r      <= pick_w_r;
                  gnt_init <= (pick == SRC_INIT);
                  gnt_wr   <= (pick == SRC_WR);
                  gnt_rd   <= (pick == SRC_RD);
                  busy     <= 1'b1;
                  if (pick == SRC_WR)
                     last_rw <= 1'b0;
                  else if (pick == SRC_RD)
                     last_rw <= 1'b1;
               end
            end
            GRANT: begin
               state <= XFER;
               count <= '0;
               do_it <= 1'b1;
            end
            XFER: begin
               // The engine cannot be interrupted, so nothing but reset leaves XFER early.
               if (count == TXN_LAST) begin
                  state     <= GAP;
                  count     <= '0;
                  do_it     <= 1'b0;
                  sel       <= SRC_NONE;
                  gnt_init  <= 1'b0;
                  gnt_wr    <= 1'b0;
                  gnt_rd    <= 1'b0;
                  done_init <= (owner == SRC_INIT);
                  done_wr   <= (owner == SRC_WR);
                  done_rd   <= (owner == SRC_RD);
               end else begin
                  count <= count + 6'd1;
               end
            end
            GAP: begin
               if (count == GAP_LAST) begin
                  state <= IDLE;
                  count <= '0;
                  owner <= SRC_NONE;
                  busy  <= 1'b0;
               end else begin
                  count <= count + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
